systolic_array_sequencer: RTL and testbench
===========================================

Name: systolic_array_sequencer

Overview:
- Controller that owns one N×N systolic array multiplier (8-bit operands, 16-bit per-PE results, per-PE PDONE).
- Buffers an N×K A matrix and a K×N B matrix from a host write port, then clears the array.
- Streams operands into the array with diagonal skew, waits for all PDONE bits, and captures the results.
- Presents the results through a valid/ready handshake. Sits between the host/DMA side and the array instance.

Parameters:
- N, 2, array dimension; must equal the array's N.
- K, 2, inner (reduction) dimension, K ≥ 1.
- TIMEOUT, 64, max cycles in WAIT before aborting.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  operand buffer write strobe; ignored unless state is IDLE.
- wr_sel  in  1  0 = A buffer, 1 = B buffer.
- wr_addr  in  clog2(N*K)  row-major index: A[i][k] = i*K+k, B[k][j] = k*N+j.
- wr_data  in  8  operand byte.
- start  in  1  begin a multiply; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- arr_rst  out  1  array clear, registered, active-high.
- arr_a  out  8×N  row operand per array row i.
- arr_b  out  8×N  column operand per array column j.
- arr_pdone  in  N*N  PDONE bits, index i*N+j.
- arr_out  in  16×N*N  array results, index i*N+j.
- res_valid  out  1  result bank holds unconsumed data.
- res_ready  in  1  consumer accepts the result.
- res_data  out  16×N*N  captured results, index i*N+j.
- err_timeout  out  1  sticky; set on WAIT timeout, cleared by the next accepted start.

Behaviour:
- Reset values: state IDLE; all outputs 0; arr_a, arr_b and res_data are 0. Operand buffers are not reset.
- States: IDLE → CLEAR → FEED → WAIT → DONE → IDLE.
- IDLE:
  - wr_en writes the selected buffer on the clock edge. An out-of-range addr is dropped.
  - start → CLEAR and clears err_timeout.
  - If start and wr_en are both high in the same cycle, the write commits first and start still advances.
- CLEAR: exactly 2 cycles with arr_rst=1 and arr_a/arr_b=0, then → FEED with t=0.
- FEED: F = K + 2(N−1) cycles, t = 0..F−1.
  - arr_a[i] = A[i][t−i] when 0 ≤ t−i < K, else 0.
  - arr_b[j] = B[t−j][j] when 0 ≤ t−j < K, else 0.
  - Operands are registered: the value computed for t appears on the pins during cycle t.
  - After t=F−1 → WAIT.
- WAIT:
  - arr_a/arr_b = 0 and the cycle counter restarts at 0.
  - If arr_pdone is all ones: capture arr_out into res_data on that edge, set res_valid=1, → DONE.
  - If TIMEOUT cycles elapse without that: set err_timeout=1, capture arr_out anyway, set res_valid=1, → DONE.
- DONE: res_data holds stable. When res_valid && res_ready: res_valid → 0 next edge, → IDLE.
- start is ignored outside IDLE, with no queuing. busy=1 in CLEAR, FEED, WAIT and DONE.
- Widths: the counter covers max(F, TIMEOUT). Results are taken as 16-bit unsigned from the array, with no saturation by this block.
- Asynchronous rst mid-operation returns to IDLE immediately and drops res_valid. Buffer contents are undefined after reset.

Decomposition:
- Package systolic_pkg:
  - state enum {IDLE, CLEAR, FEED, WAIT, DONE}.
  - OPW=8, RESW=16, CLEAR_CYCLES=2.
  - function feed_len(N, K).
- One sub-module, skew_feeder: given t and a buffer read view, produces registered arr_a/arr_b with the diagonal skew and zero padding. It is instantiated once.
- The FSM, buffers, timeout counter and result bank stay in the top module.

Test Plan:
- N=2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start, all PDONE after FEED → res_data = {19,22,43,50}. Check CLEAR is 2 cycles, FEED is 4 cycles, and arr_a[1]=0 at t=0.
- Skew check, N=2, K=2: per cycle t=0..3, arr_a = {(1,0),(2,3),(0,4),(0,0)} and arr_b = {(5,0),(7,6),(0,8),(0,0)}.
- Hold arr_pdone=4'b0111 for the whole WAIT with TIMEOUT=8 → err_timeout=1 after 8 WAIT cycles, res_valid=1. The next start clears err_timeout.
- Backpressure: res_ready=0 for 10 cycles in DONE → res_data stable and busy=1. Then res_ready=1 → res_valid drops next cycle, IDLE. A start during DONE is ignored.
- Writes outside IDLE: wr_en during FEED with A[0][0]=99 → buffer unchanged, result identical to the first test.
- Async rst asserted mid-FEED (t=2) → outputs 0 immediately, state IDLE. Reload and restart → correct result.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
// No ports: provides the FSM state enum, operand/result widths, the
// length of the array clear phase and the skewed feed length helper.
package systolic_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, DONE} state_t;

    localparam int OPW          = 8;
    localparam int RESW         = 16;
    localparam int CLEAR_CYCLES = 2;

    // Cycles needed to push K operands through the last diagonal of an NxN array.
    function automatic int feed_len(input int n, input int k);
        return k + 2 * (n - 1);
    endfunction

endpackage

// File: rtl/systolic_array_sequencer_if.sv
// Bundle of every non-clock signal of the sequencer.
//   host side : wr_en, wr_sel, wr_addr, wr_data, start, busy
//   array side: arr_rst, arr_a, arr_b, arr_pdone, arr_out
//   result    : res_valid, res_ready, res_data, err_timeout
// slave  = the sequencer itself, master = host plus array environment.
interface systolic_array_sequencer_if #(
    parameter int N = 2,
    parameter int K = 2
);
    import systolic_pkg::*;

    localparam int AW = (N * K > 1) ? $clog2(N * K) : 1;

    logic                          wr_en;
    logic                          wr_sel;
    logic [AW-1:0]                 wr_addr;
    logic [OPW-1:0]                wr_data;
    logic                          start;
    logic                          busy;
    logic                          arr_rst;
    logic [N-1:0][OPW-1:0]         arr_a;
    logic [N-1:0][OPW-1:0]         arr_b;
    logic [N*N-1:0]                arr_pdone;
    logic [N*N-1:0][RESW-1:0]      arr_out;
    logic                          res_valid;
    logic                          res_ready;
    logic [N*N-1:0][RESW-1:0]      res_data;
    logic                          err_timeout;

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, arr_pdone, arr_out, res_ready,
        output busy, arr_rst, arr_a, arr_b, res_valid, res_data, err_timeout
    );

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, arr_pdone, arr_out, res_ready,
        input  busy, arr_rst, arr_a, arr_b, res_valid, res_data, err_timeout
    );

endinterface

// File: rtl/skew_feeder.sv
// Diagonal-skew operand feeder for an NxN systolic array.
//   clk, rst : clock, async active-high reset (clears operands)
//   load     : next cycle is a feed cycle; otherwise operands go to zero
//   t        : feed step that will be on the pins next cycle
//   a_buf    : A operands, row-major A[i][k] at i*K+k
//   b_buf    : B operands, row-major B[k][j] at k*N+j
//   arr_a    : registered row operands,    arr_a[i] = A[i][t-i]
//   arr_b    : registered column operands, arr_b[j] = B[t-j][j]
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int N  = 2,
    parameter int K  = 2,
    parameter int TW = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [TW-1:0]              t,
    input  logic [N*K-1:0][OPW-1:0]    a_buf,
    input  logic [N*K-1:0][OPW-1:0]    b_buf,
    output logic [N-1:0][OPW-1:0]      arr_a,
    output logic [N-1:0][OPW-1:0]      arr_b
);

    localparam int DEPTH = N * K;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0][OPW-1:0] a_nxt;
    logic [N-1:0][OPW-1:0] b_nxt;
    int                    d;
    logic [AW-1:0]         ai;
    logic [AW-1:0]         bi;

    // Lane i (or j) lags lane 0 by i steps; outside its K-step window it feeds zero.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        d     = 0;
        ai    = '0;
        bi    = '0;
        for (int i = 0; i < N; i++) begin
            d = int'(t) - i;
            if (load && d >= 0 && d < K) begin
                ai       = AW'(i * K + d);
                a_nxt[i] = a_buf[ai];
            end
        end
        for (int j = 0; j < N; j++) begin
            d = int'(t) - j;
            if (load && d >= 0 && d < K) begin
                bi       = AW'(d * N + j);
                b_nxt[j] = b_buf[bi];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_a <= '0;
            arr_b <= '0;
        end else begin
            arr_a <= a_nxt;
            arr_b <= b_nxt;
        end
    end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Sequencer for one NxN systolic array multiplier: buffers A (NxK) and
// B (KxN) from the host, clears the array, streams skewed operands,
// waits for all PDONE bits (or TIMEOUT cycles) and holds the captured
// results behind a valid/ready handshake.
//   clk, rst : clock, async active-high reset
//   bus      : systolic_array_sequencer_if.slave (host, array and result signals)
//
// state | meaning
// IDLE  | accept operand writes, wait for start
// CLEAR | arr_rst high for CLEAR_CYCLES cycles
// FEED  | skewed operands on arr_a/arr_b, t = 0..F-1
// WAIT  | operands zero, wait for all PDONE or timeout
// DONE  | results valid, wait for res_ready
module systolic_array_sequencer
    import systolic_pkg::*;
#(
    parameter int N       = 2,
    parameter int K       = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    systolic_array_sequencer_if.slave  bus
);

    localparam int F     = feed_len(N, K);
    localparam int CMAX0 = (F > TIMEOUT) ? F : TIMEOUT;
    localparam int CMAX  = (CMAX0 > CLEAR_CYCLES) ? CMAX0 : CLEAR_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int DEPTH = N * K;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt, cnt_nxt;
    logic [CW-1:0]               t_nxt;
    logic [DEPTH-1:0][OPW-1:0]   a_buf;
    logic [DEPTH-1:0][OPW-1:0]   b_buf;
    logic [N*N-1:0][RESW-1:0]    res_q;
    logic                        res_valid_q;
    logic                        err_q;
    logic                        arr_rst_q;
    logic                        all_done;
    logic                        capture;
    logic                        timeout_hit;

    assign all_done = &bus.arr_pdone;

    // Operand buffers carry no reset; their content is undefined after rst.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.wr_en && int'(bus.wr_addr) < DEPTH) begin
            if (bus.wr_sel) b_buf[bus.wr_addr] <= bus.wr_data;
            else            a_buf[bus.wr_addr] <= bus.wr_data;
        end
    end

    // cnt is a down-counter loaded with (phase length - 1); phases end at zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = CW'(CLEAR_CYCLES - 1);
                end
            end
            CLEAR: begin
                if (cnt == '0) begin
                    state_nxt = FEED;
                    cnt_nxt   = CW'(F - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            FEED: begin
                if (cnt == '0) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(TIMEOUT - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            WAIT: begin
                if (all_done || cnt == '0) begin
                    capture     = 1'b1;
                    timeout_hit = !all_done;
                    state_nxt   = DONE;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                if (res_valid_q && bus.res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            arr_rst_q   <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            res_q       <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            arr_rst_q <= (state_nxt == CLEAR);
            if (capture) begin
                res_q       <= bus.arr_out;
                res_valid_q <= 1'b1;
            end else if (state == DONE && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
            if (state == IDLE && bus.start) err_q <= 1'b0;
            else if (timeout_hit)           err_q <= 1'b1;
        end
    end

    // Feed step for the next cycle, so the registered operands line up with t.
    assign t_nxt = CW'(F - 1) - cnt_nxt;

    skew_feeder #(.N(N), .K(K), .TW(CW)) u_feeder (
        .clk   (clk),
        .rst   (rst),
        .load  (state_nxt == FEED),
        .t     (t_nxt),
        .a_buf (a_buf),
        .b_buf (b_buf),
        .arr_a (bus.arr_a),
        .arr_b (bus.arr_b)
    );

    assign bus.busy        = (state != IDLE);
    assign bus.arr_rst     = arr_rst_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
module tb_systolic_array_sequencer;
    import systolic_pkg::*;

    localparam int N       = 2;
    localparam int K       = 2;
    localparam int TIMEOUT = 8;
    localparam int F       = K + 2 * (N - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    int             ma [N][K];
    int             mb [K][N];
    logic [OPW-1:0] a_hist [F][N];
    logic [OPW-1:0] b_hist [F][N];

    systolic_array_sequencer_if #(.N(N), .K(K)) bus ();

    systolic_array_sequencer #(.N(N), .K(K), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.wr_sel    = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        bus.arr_pdone = '0;
        bus.arr_out   = '0;
    endtask

    task automatic write_op(input bit sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = addr[1:0];
        bus.wr_data = data[7:0];
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic load_mats();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) write_op(1'b0, i * K + k, ma[i][k]);
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) write_op(1'b1, k * N + j, mb[k][j]);
    endtask

    task automatic randomize_mats();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) ma[i][k] = int'($urandom_range(0, 255));
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) mb[k][j] = int'($urandom_range(0, 255));
    endtask

    // One complete multiply from a negedge in IDLE. abort_t >= 0 fires rst at that feed step.
    task automatic do_run(input bit tmo, input int pd_delay, input int hold,
                          input bit feed_write, input int abort_t);
        int ncl;
        int w;
        int ea, eb, acc;
        logic [N*N-1:0][RESW-1:0] exp_res;
        logic [N*N-1:0][RESW-1:0] model;
        logic [N*N-1:0]           part;

        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < K; k++) acc += ma[i][k] * mb[k][j];
                exp_res[i*N+j] = 16'(acc);
            end

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", bus.busy); end
        vectors++;
        if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL err_cleared_by_start: got %b want 0", bus.err_timeout); end

        ncl = 0;
        while (bus.arr_rst === 1'b1 && ncl < 10) begin
            vectors++;
            if (bus.arr_a !== '0 || bus.arr_b !== '0) begin
                errors++; $display("FAIL clear_operands: a=%h b=%h want 0", bus.arr_a, bus.arr_b);
            end
            ncl++;
            @(negedge clk);
        end
        vectors++;
        if (ncl != CLEAR_CYCLES) begin errors++; $display("FAIL clear_len: got %0d want %0d", ncl, CLEAR_CYCLES); end

        for (int t = 0; t < F; t++) begin
            for (int i = 0; i < N; i++) begin
                ea = (t - i >= 0 && t - i < K) ? ma[i][t-i] : 0;
                eb = (t - i >= 0 && t - i < K) ? mb[t-i][i] : 0;
                a_hist[t][i] = bus.arr_a[i];
                b_hist[t][i] = bus.arr_b[i];
                vectors++;
                if (bus.arr_a[i] !== 8'(ea)) begin
                    errors++; $display("FAIL feed_a t=%0d i=%0d: got %0d want %0d", t, i, bus.arr_a[i], ea);
                end
                vectors++;
                if (bus.arr_b[i] !== 8'(eb)) begin
                    errors++; $display("FAIL feed_b t=%0d j=%0d: got %0d want %0d", t, i, bus.arr_b[i], eb);
                end
            end
            if (feed_write && t == 1) begin
                bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'd99;
            end
            if (t == abort_t) begin
                rst = 1'b1;
                #1;
                vectors++;
                if (bus.busy !== 1'b0 || bus.arr_a !== '0 || bus.arr_b !== '0 ||
                    bus.res_valid !== 1'b0 || bus.arr_rst !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: busy=%b a=%h b=%h valid=%b arr_rst=%b want all 0",
                             bus.busy, bus.arr_a, bus.arr_b, bus.res_valid, bus.arr_rst);
                end
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                vectors++;
                if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b want 0", bus.busy); end
                return;
            end
            @(negedge clk);
            bus.wr_en = 1'b0;
        end

        vectors++;
        if (bus.arr_a !== '0 || bus.arr_b !== '0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL wait_entry: a=%h b=%h busy=%b want 0 0 1", bus.arr_a, bus.arr_b, bus.busy);
        end

        // Behavioural array: PE(i,j) sees row i delayed by j and column j delayed by i.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int t = 0; t < F; t++)
                    if (t - j >= 0 && t - i >= 0)
                        acc += int'(a_hist[t-j][i]) * int'(b_hist[t-i][j]);
                model[i*N+j] = 16'(acc);
            end
        bus.arr_out = model;

        part = '1;
        part[N*N-1] = 1'b0;
        w = 0;
        while (bus.res_valid !== 1'b1 && w < TIMEOUT + 20) begin
            if (tmo) bus.arr_pdone = part;
            else if (w >= pd_delay) bus.arr_pdone = '1;
            w++;
            @(negedge clk);
        end
        bus.arr_pdone = '0;
        bus.arr_out   = {N*N{16'($urandom)}};
        vectors++;
        if (w != (tmo ? TIMEOUT : pd_delay + 1)) begin
            errors++; $display("FAIL wait_len: got %0d want %0d", w, tmo ? TIMEOUT : pd_delay + 1);
        end
        vectors++;
        if (bus.err_timeout !== tmo) begin errors++; $display("FAIL err_timeout: got %b want %b", bus.err_timeout, tmo); end
        vectors++;
        if (bus.res_data !== exp_res) begin errors++; $display("FAIL result: got %h want %h", bus.res_data, exp_res); end

        for (int h = 0; h < hold; h++) begin
            bus.start = (h == 0);
            vectors++;
            if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1 || bus.res_data !== exp_res) begin
                errors++;
                $display("FAIL backpressure h=%0d: valid=%b busy=%b data=%h want 1 1 %h",
                         h, bus.res_valid, bus.busy, bus.res_data, exp_res);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL handshake: valid=%b busy=%b want 0 0", bus.res_valid, bus.busy);
        end
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_queued_start: busy=%b want 0", bus.busy); end
        vectors++;
        if (bus.err_timeout !== tmo) begin errors++; $display("FAIL err_sticky: got %b want %b", bus.err_timeout, tmo); end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.arr_rst !== 1'b0 || bus.res_valid !== 1'b0 || bus.err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b arr_rst=%b valid=%b err=%b want 0",
                     bus.busy, bus.arr_rst, bus.res_valid, bus.err_timeout);
        end
        vectors++;
        if (bus.arr_a !== '0 || bus.arr_b !== '0 || bus.res_data !== '0) begin
            errors++; $display("FAIL reset_data: a=%h b=%h res=%h want 0", bus.arr_a, bus.arr_b, bus.res_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        ma = '{'{1, 2}, '{3, 4}};
        mb = '{'{5, 6}, '{7, 8}};
        load_mats();
        do_run(1'b0, 0, 0, 1'b0, -1);
    endtask

    task automatic test_skew();
        int sk_a [F][N];
        int sk_b [F][N];
        sk_a = '{'{1, 0}, '{2, 3}, '{0, 4}, '{0, 0}};
        sk_b = '{'{5, 0}, '{7, 6}, '{0, 8}, '{0, 0}};
        for (int t = 0; t < F; t++)
            for (int i = 0; i < N; i++) begin
                vectors++;
                if (a_hist[t][i] !== 8'(sk_a[t][i]) || b_hist[t][i] !== 8'(sk_b[t][i])) begin
                    errors++;
                    $display("FAIL skew_table t=%0d lane=%0d: a=%0d b=%0d want %0d %0d",
                             t, i, a_hist[t][i], b_hist[t][i], sk_a[t][i], sk_b[t][i]);
                end
            end
    endtask

    task automatic test_timeout();
        randomize_mats();
        load_mats();
        do_run(1'b1, 0, 0, 1'b0, -1);
        do_run(1'b0, 2, 0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        do_run(1'b0, 1, 10, 1'b0, -1);
    endtask

    task automatic test_feed_write();
        ma = '{'{1, 2}, '{3, 4}};
        mb = '{'{5, 6}, '{7, 8}};
        load_mats();
        do_run(1'b0, 0, 0, 1'b1, -1);
        do_run(1'b0, 0, 0, 1'b0, -1);
    endtask

    task automatic test_async_reset();
        do_run(1'b0, 0, 0, 1'b0, 2);
        idle_inputs();
        randomize_mats();
        load_mats();
        do_run(1'b0, 0, 0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            randomize_mats();
            for (int i = 0; i < N; i++)
                for (int k = 0; k < K; k++) write_op(1'b0, i * K + k, ma[i][k]);
            for (int k = 0; k < K; k++)
                for (int j = 0; j < N; j++)
                    if (!(k == K - 1 && j == N - 1)) write_op(1'b1, k * N + j, mb[k][j]);
            // Final write shares the start cycle and must still land.
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b1;
            bus.wr_addr = 2'(K * N - 1);
            bus.wr_data = 8'(mb[K-1][N-1]);
            do_run(1'b0, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_timeout();
        test_backpressure();
        test_feed_write();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
